// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   state_e : arbiter FSM states
//   grant_e : which requester owns the current transaction
//   MEM_LAT_DEF : default memory read latency in cycles (legal 1..15)
//   CNT_W : width of the latency down-counter
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_DEF = 2;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_D
  } grant_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection between fetch and data ports.
// Optional feature macro: MEM_ARBITER_RR_EN (round-robin on conflict;
// otherwise data always beats fetch).
// Ports:
//   if_req_i  fetch request
//   d_req_i   data request
//   last_d_i  last grant went to data (round-robin build only)
//   gnt_o     selected grant, GNT_NONE when nobody asks
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req_i,
  input  logic   d_req_i,
`ifdef MEM_ARBITER_RR_EN
  input  logic   last_d_i,
`endif
  output grant_e gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (if_req_i && d_req_i) begin
`ifdef MEM_ARBITER_RR_EN
      // the port that did not win last time takes this conflict
      gnt_o = last_d_i ? GNT_IF : GNT_D;
`else
      gnt_o = GNT_D;
`endif
    end else if (d_req_i) begin
      gnt_o = GNT_D;
    end else if (if_req_i) begin
      gnt_o = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// and data-access ports. One transaction at a time: grant, issue, wait for
// MEM_LAT, respond. Occupancy is MEM_LAT+2 cycles per access.
// Optional feature macro: MEM_ARBITER_RR_EN (round-robin arbitration).
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   if_req/if_addr        fetch request and address
//   if_rdata/if_valid     fetch response (rdata zero unless valid)
//   if_stall              fetch request not yet completing
//   d_req/d_we/d_addr/d_wdata  data request (d_we==0 is a load)
//   d_rdata/d_valid/d_stall    data response and stall
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory issue
//   mem_rdata             memory read data, valid MEM_LAT cycles after mem_en
//
// state | meaning
// IDLE  | no transaction; pick a requester and register its fields
// WAIT  | mem_en cycle onward; down-counter runs to 0 (MEM_LAT cycles total)
// RESP  | granted port sees valid and mem_rdata this cycle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;
  // The issue cycle itself is the first WAIT cycle, so loading MEM_LAT-1
  // places RESP exactly MEM_LAT cycles after mem_en; MEM_LAT=1 needs no
  // extra wait cycle beyond the issue.
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  grant_e            gnt_q, gnt_d;
  grant_e            pick_gnt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic [BE_W-1:0]   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              resp_live;

`ifdef MEM_ARBITER_RR_EN
  logic last_d_q, last_d_d;
`endif

  mem_arb_pick u_pick (
    .if_req_i (if_req),
    .d_req_i  (d_req),
`ifdef MEM_ARBITER_RR_EN
    .last_d_i (last_d_q),
`endif
    .gnt_o    (pick_gnt)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARBITER_RR_EN
    last_d_d    = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_gnt != GNT_NONE) begin
          gnt_d    = pick_gnt;
          mem_en_d = 1'b1;
          cnt_d    = LAT_M1;
          state_d  = WAIT;
`ifdef MEM_ARBITER_RR_EN
          last_d_d = (pick_gnt == GNT_D);
`endif
          if (pick_gnt == GNT_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = '0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_NONE;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARBITER_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  // Gate with reset so a response landing while reset is held never pulses.
  assign resp_live = (state_q == RESP) && reset;

  assign if_valid  = resp_live && (gnt_q == GNT_IF);
  assign d_valid   = resp_live && (gnt_q == GNT_D);
  assign if_rdata  = if_valid ? mem_rdata : '0;
  assign d_rdata   = d_valid ? mem_rdata : '0;
  assign if_stall  = if_req & ~if_valid;
  assign d_stall   = d_req & ~d_valid;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  parameter int LAT = 2;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, if_valid, d_valid, if_stall, d_stall, mem_en;
  logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_we, mem_we;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;
  bit last_d = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'h0050_0093 : (32'hA500_0000 | 32'(i * 7));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // memory device driven by the DUT's issue outputs
  logic [31:0] dev_mem [256];
  bit          dev_w   [256];
  int          cyc = 0;
  int          pend_due = -100;
  logic [31:0] pend_data = 32'h0;
  logic [31:0] junk = 32'h1357_9BDF;

  function automatic logic [31:0] dev_word(input logic [7:0] i);
    return dev_w[i] ? dev_mem[i] : init_word(int'(i));
  endfunction

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    junk <= $urandom;
    if (mem_en) begin
      pend_due          <= cyc + LAT;
      pend_data         <= dev_word(mem_addr[9:2]);
      dev_mem[mem_addr[9:2]] <= merge(dev_word(mem_addr[9:2]), mem_we, mem_wdata);
      dev_w[mem_addr[9:2]]   <= 1'b1;
    end
  end
  assign mem_rdata = (cyc == pend_due) ? pend_data : junk;

  // reference memory contents as the spec says they should evolve
  logic [31:0] ref_mem [256];
  bit          ref_w   [256];

  function automatic logic [31:0] ref_word(input logic [7:0] i);
    return ref_w[i] ? ref_mem[i] : init_word(int'(i));
  endfunction

  task automatic ref_store(input logic [7:0] i, input logic [3:0] we, input logic [31:0] wd);
    ref_mem[i] = merge(ref_word(i), we, wd);
    ref_w[i]   = 1'b1;
  endtask

  // expected winner: sole requester, else data (fixed) or the port not served last (RR)
  function automatic bit exp_win_d(input bit want_if, input bit want_d, input bit last_was_d);
    if (want_if && want_d) return RR ? !last_was_d : 1'b1;
    return want_d;
  endfunction

  task automatic run_single(input bit is_d, input logic [31:0] addr, input logic [3:0] we,
                            input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                            output logic [3:0] o_we, output logic [31:0] o_addr, output logic [31:0] o_wdata,
                            output int n_en, output int n_bad, output bit to);
    int en_c;
    en_c = -1000; lat = -1; rdata = '0; o_we = '0; o_addr = '0; o_wdata = '0;
    n_en = 0; n_bad = 0; to = 1'b1;
    if (is_d) begin d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    for (int k = 0; k < LAT + 40; k++) begin
      @(negedge clk);
      if (mem_en) begin n_en++; en_c = cyc; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata; end
      if (is_d ? if_valid : d_valid) n_bad++;
      if (is_d ? d_valid : if_valid) begin
        lat = cyc - en_c; rdata = is_d ? d_rdata : if_rdata;
        if (is_d ? d_stall : if_stall) n_bad++;
        to = 1'b0;
        break;
      end else begin
        if (!(is_d ? d_stall : if_stall)) n_bad++;
        if ((is_d ? d_rdata : if_rdata) !== 32'h0) n_bad++;
      end
    end
    if_req = 1'b0; d_req = 1'b0; d_we = '0;
    if (!to) last_d = is_d;
  endtask

  task automatic test_reset();
    int en_k, v_k;
    logic [31:0] rd;
    reset = 1'b0; d_req = 1'b1; d_addr = 32'h40; d_we = '0; d_wdata = '0;
    if_req = 1'b0; if_addr = '0;
    repeat (3) begin
      @(negedge clk);
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
      checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL rst_d_valid got=%b exp=0", d_valid); end
      checks++; if (d_stall !== 1'b1) begin failures++; $display("FAIL rst_d_stall got=%b exp=1", d_stall); end
      checks++; if (if_stall !== 1'b0) begin failures++; $display("FAIL rst_if_stall got=%b exp=0", if_stall); end
      checks++; if ({mem_we, mem_addr, mem_wdata} !== 68'h0) begin
        failures++; $display("FAIL rst_mem_regs got=%h/%h/%h exp=0", mem_we, mem_addr, mem_wdata); end
    end
    reset = 1'b1; last_d = 1'b0;
    en_k = -1; v_k = -1; rd = '0;
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge clk);
      if (mem_en && en_k < 0) en_k = k;
      if (d_valid) begin v_k = k; rd = d_rdata; break; end
    end
    d_req = 1'b0;
    checks++; if (en_k !== 0) begin failures++; $display("FAIL rst_first_issue got=%0d exp=0", en_k); end
    checks++; if (v_k !== LAT) begin failures++; $display("FAIL rst_first_valid got=%0d exp=%0d", v_k, LAT); end
    checks++; if (rd !== ref_word(8'h10)) begin failures++; $display("FAIL rst_first_rdata got=%h exp=%h", rd, ref_word(8'h10)); end
    last_d = 1'b1;
  endtask

  task automatic test_fetch();
    int lat, n_en, n_bad; bit to;
    logic [31:0] rd, oa, ow; logic [3:0] owe;
    run_single(1'b0, 32'h100, 4'h0, 32'h0, lat, rd, owe, oa, ow, n_en, n_bad, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL fetch_timeout got=%b exp=0", to); end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL fetch_lat got=%0d exp=%0d", lat, LAT); end
    checks++; if (rd !== 32'h0050_0093) begin failures++; $display("FAIL fetch_rdata got=%h exp=00500093", rd); end
    checks++; if (n_en !== 1) begin failures++; $display("FAIL fetch_en_pulses got=%0d exp=1", n_en); end
    checks++; if (oa !== 32'h100 || owe !== 4'h0) begin failures++; $display("FAIL fetch_issue got=%h/%h exp=100/0", oa, owe); end
    checks++; if (n_bad !== 0) begin failures++; $display("FAIL fetch_handshake got=%0d exp=0", n_bad); end
  endtask

  task automatic test_store();
    int lat, n_en, n_bad; bit to;
    logic [31:0] rd, oa, ow; logic [3:0] owe;
    run_single(1'b1, 32'h2004, 4'b0011, 32'hDEAD_BEEF, lat, rd, owe, oa, ow, n_en, n_bad, to);
    ref_store(8'h01, 4'b0011, 32'hDEAD_BEEF);
    checks++; if (to !== 1'b0 || lat !== LAT) begin failures++; $display("FAIL store_lat got=%0d exp=%0d", lat, LAT); end
    checks++; if (owe !== 4'b0011) begin failures++; $display("FAIL store_we got=%b exp=0011", owe); end
    checks++; if (oa !== 32'h2004) begin failures++; $display("FAIL store_addr got=%h exp=00002004", oa); end
    checks++; if (ow !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_wdata got=%h exp=deadbeef", ow); end
    checks++; if (n_en !== 1 || n_bad !== 0) begin failures++; $display("FAIL store_handshake got=%0d/%0d exp=1/0", n_en, n_bad); end
    run_single(1'b1, 32'h2004, 4'h0, 32'h0, lat, rd, owe, oa, ow, n_en, n_bad, to);
    checks++; if (rd !== ref_word(8'h01)) begin failures++; $display("FAIL store_readback got=%h exp=%h", rd, ref_word(8'h01)); end
  endtask

  task automatic test_priority();
    int last_v, n;
    bit got_d, want;
    logic [31:0] rd;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; last_d = 1'b0;
    if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    d_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    d_we = '0; if_req = 1'b1; d_req = 1'b1;
    last_v = -1; n = 0;
    for (int k = 0; k < 4 * (LAT + 3) + 20 && n < 4; k++) begin
      @(negedge clk);
      if (if_valid && d_valid) begin checks++; failures++; $display("FAIL prio_double_valid got=11 exp=one"); end
      if (!if_valid && if_stall !== 1'b1) begin checks++; failures++; $display("FAIL prio_if_stall got=%b exp=1", if_stall); end
      if (if_valid || d_valid) begin
        got_d = d_valid;
        want  = exp_win_d(1'b1, 1'b1, last_d);
        checks++; if (got_d !== want) begin failures++; $display("FAIL prio_grant n=%0d got_d=%b exp_d=%b", n, got_d, want); end
        rd = got_d ? d_rdata : if_rdata;
        checks++; if (rd !== ref_word(got_d ? d_addr[9:2] : if_addr[9:2])) begin
          failures++; $display("FAIL prio_rdata got=%h exp=%h", rd, ref_word(got_d ? d_addr[9:2] : if_addr[9:2])); end
        if (last_v >= 0) begin
          checks++; if (cyc - last_v !== LAT + 2) begin failures++; $display("FAIL prio_gap got=%0d exp=%0d", cyc - last_v, LAT + 2); end
        end
        last_v = cyc; last_d = got_d; n++;
        if (got_d) d_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        else if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL prio_timeout got=%0d exp=4", n); end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n_v, en_c, lat;
    logic [31:0] rd;
    d_req = 1'b1; d_addr = 32'h80; d_we = '0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_en) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rmid_issue got=none exp=mem_en"); end
    reset = 1'b0; d_addr = 32'h84; last_d = 1'b0;
    n_v = 0;
    repeat (2) begin
      @(negedge clk);
      if (d_valid || if_valid) n_v++;
      checks++; if (d_stall !== 1'b1 || mem_en !== 1'b0) begin
        failures++; $display("FAIL rmid_in_reset got=%b/%b exp=1/0", d_stall, mem_en); end
    end
    reset = 1'b1;
    en_c = -1; lat = -1; rd = '0;
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_c = cyc;
        checks++; if (mem_addr !== 32'h84) begin failures++; $display("FAIL rmid_fresh_addr got=%h exp=00000084", mem_addr); end
      end
      if (d_valid || if_valid) begin
        if (en_c < 0 || if_valid) n_v++;
        else begin lat = cyc - en_c; rd = d_rdata; break; end
      end
    end
    d_req = 1'b0;
    checks++; if (n_v !== 0) begin failures++; $display("FAIL rmid_stray_valid got=%0d exp=0", n_v); end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL rmid_lat got=%0d exp=%0d", lat, LAT); end
    checks++; if (rd !== ref_word(8'h21)) begin failures++; $display("FAIL rmid_rdata got=%h exp=%h", rd, ref_word(8'h21)); end
    last_d = 1'b1;
  endtask

  task automatic test_random();
    bit p_if, p_d, got_d, want, done;
    int pat, en_c;
    logic [31:0] rd, exp_rd;
    for (int it = 0; it < 30; it++) begin
      pat = $urandom_range(1, 3);
      p_if = pat[0]; p_d = pat[1];
      if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      d_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      d_wdata = $urandom;
      d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if_req = p_if; d_req = p_d;
      en_c = -1000; done = 1'b0;
      for (int k = 0; k < 2 * (LAT + 3) + 10 && !done; k++) begin
        @(negedge clk);
        if (mem_en) en_c = cyc;
        if (if_valid && d_valid) begin checks++; failures++; $display("FAIL rnd_double_valid it=%0d", it); end
        if ((!if_valid && if_rdata !== 32'h0) || (!d_valid && d_rdata !== 32'h0)) begin
          checks++; failures++; $display("FAIL rnd_idle_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
        if (if_valid || d_valid) begin
          got_d = d_valid;
          want  = exp_win_d(p_if, p_d, last_d);
          checks++; if (got_d !== want) begin failures++; $display("FAIL rnd_grant it=%0d got_d=%b exp_d=%b", it, got_d, want); end
          checks++; if (cyc - en_c !== LAT) begin failures++; $display("FAIL rnd_lat it=%0d got=%0d exp=%0d", it, cyc - en_c, LAT); end
          rd = got_d ? d_rdata : if_rdata;
          if (!got_d || d_we == 4'h0) begin
            exp_rd = ref_word(got_d ? d_addr[9:2] : if_addr[9:2]);
            checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, rd, exp_rd); end
          end else begin
            ref_store(d_addr[9:2], d_we, d_wdata);
          end
          last_d = got_d;
          if (got_d) begin p_d = 1'b0; d_req = 1'b0; end
          else begin p_if = 1'b0; if_req = 1'b0; end
          done = !p_if && !p_d;
        end
      end
      checks++; if (!done) begin failures++; $display("FAIL rnd_timeout it=%0d pending=%b%b", it, p_if, p_d); end
      if_req = 1'b0; d_req = 1'b0; d_we = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
